// File: rtl/stage_decode_redirect_pkg.sv
// Shared constants for the decode/redirect stage: opcodes, branch funct3 codes,
// fetch PC-select encodings and immediate-format selector.
package stage_decode_redirect_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage_decode_redirect_imm_gen.sv
// Combinational immediate generator: all RV32I immediate formats plus the
// format the opcode actually uses.
module imm_gen
    import stage_decode_redirect_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_i_o,
    output logic [31:0] imm_s_o,
    output logic [31:0] imm_b_o,
    output logic [31:0] imm_u_o,
    output logic [31:0] imm_j_o,
    output imm_sel_e    imm_sel_o
);

    assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u_o = {instr_i[31:12], 12'b0};
    assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        imm_sel_o = IMM_NONE;
        case (instr_i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_sel_o = IMM_I;
            OPC_STORE:                      imm_sel_o = IMM_S;
            OPC_BRANCH:                     imm_sel_o = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_sel_o = IMM_U;
            OPC_JAL:                        imm_sel_o = IMM_J;
            default:                        imm_sel_o = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/stage_decode_redirect.sv
// Decode stage: holds the fetched instruction, resolves jumps/branches into a
// one-cycle redirect to fetch, stalls on load-use and feeds the execute register.
module stage_decode_redirect
    import stage_decode_redirect_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h4000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instrF,
    input  logic [XLEN-1:0] pcF,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rdX,
    input  logic            is_loadX,
    output logic            stallF,
    output logic [1:0]      pc_selD,
    output logic [XLEN-1:0] jump_result,
    output logic [XLEN-1:0] branch_result,
    output logic [XLEN-1:0] instrX,
    output logic [XLEN-1:0] pcX,
    output logic [XLEN-1:0] immX,
    output logic            validX,
    output logic            misalignX
);

    logic [XLEN-1:0] instrD_q, pcD_q, instrD_d;
    logic            validD_q, validD_d;
    logic [XLEN-1:0] instrX_q, pcX_q, immX_q;
    logic            validX_q, misalignX_q, misalignX_d;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    imm_sel_e        imm_sel;

    imm_gen u_imm_gen (
        .instr_i  (instrD_q),
        .imm_i_o  (imm_i),
        .imm_s_o  (imm_s),
        .imm_b_o  (imm_b),
        .imm_u_o  (imm_u),
        .imm_j_o  (imm_j),
        .imm_sel_o(imm_sel)
    );

    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I:   imm = imm_i;
            IMM_S:   imm = imm_s;
            IMM_B:   imm = imm_b;
            IMM_U:   imm = imm_u;
            IMM_J:   imm = imm_j;
            default: imm = '0;
        endcase
    end

    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rs1, rs2;
    logic       hz, taken, is_jump;
    assign opc = instrD_q[6:0];
    assign f3  = instrD_q[14:12];
    assign rs1 = instrD_q[19:15];
    assign rs2 = instrD_q[24:20];

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (rs1_data == rs2_data);
            F3_BNE:  taken = (rs1_data != rs2_data);
            F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: taken = (rs1_data <  rs2_data);
            F3_BGEU: taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    // Only register fields the opcode really reads can create a load-use hazard.
    assign hz = validD_q && is_loadX && (rdX != 5'd0) &&
                ((uses_rs1(opc) && (rdX == rs1)) || (uses_rs2(opc) && (rdX == rs2)));
    assign stallF = hz;

    assign is_jump       = (opc == OPC_JAL) || (opc == OPC_JALR);
    assign jump_result   = (opc == OPC_JALR) ? ((rs1_data + imm_i) & ~XLEN'(1)) : (pcD_q + imm_j);
    assign branch_result = pcD_q + imm_b;

    always_comb begin
        pc_selD = PC_SEL_SEQ;
        if (validD_q && !hz) begin
            if (is_jump)                           pc_selD = PC_SEL_JUMP;
            else if ((opc == OPC_BRANCH) && taken) pc_selD = PC_SEL_BRANCH;
        end
    end

    always_comb begin
        misalignX_d = 1'b0;
        case (pc_selD)
            PC_SEL_JUMP:   misalignX_d = jump_result[1];
            PC_SEL_BRANCH: misalignX_d = branch_result[1];
            default:       misalignX_d = 1'b0;
        endcase
    end

    assign validD_d = (instrF != '0);
    assign instrD_d = validD_d ? instrF : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            instrD_q    <= NOP_INSTR;
            pcD_q       <= RESET_PC;
            validD_q    <= 1'b0;
            instrX_q    <= NOP_INSTR;
            pcX_q       <= RESET_PC;
            immX_q      <= '0;
            validX_q    <= 1'b0;
            misalignX_q <= 1'b0;
        end else begin
            misalignX_q <= misalignX_d;
            if (hz) begin
                // Bubble into execute; D and pcX hold until the load result is forwardable.
                instrX_q <= NOP_INSTR;
                immX_q   <= '0;
                validX_q <= 1'b0;
            end else begin
                instrX_q <= validD_q ? instrD_q : NOP_INSTR;
                pcX_q    <= pcD_q;
                immX_q   <= imm;
                validX_q <= validD_q;
                instrD_q <= instrD_d;
                pcD_q    <= pcF;
                validD_q <= validD_d;
            end
        end
    end

    assign instrX    = instrX_q;
    assign pcX       = pcX_q;
    assign immX      = immX_q;
    assign validX    = validX_q;
    assign misalignX = misalignX_q;

endmodule

// File: tb/tb_stage_decode_redirect.sv
// Bench for stage_decode_redirect: directed checks from hand-computed values plus
// randomized traffic compared every cycle against a behavioural model.
module tb_stage_decode_redirect;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOPI   = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] ADD    = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] JAL16  = 32'h0100_00EF; // jal x1,+16
    localparam logic [31:0] JALR   = 32'h0001_00E7; // jalr x1,0(x2)
    localparam logic [31:0] BEQ    = 32'hFE20_8CE3; // beq x1,x2,-8
    localparam logic [31:0] BLT    = 32'hFE20_CCE3;
    localparam logic [31:0] BLTU   = 32'hFE20_ECE3;

    logic        clk, rst, is_loadX;
    logic [31:0] instrF, pcF, rs1_data, rs2_data;
    logic [4:0]  rdX;
    logic        stallF, validX, misalignX;
    logic [1:0]  pc_selD;
    logic [31:0] jump_result, branch_result, instrX, pcX, immX;

    int n_cmp = 0;
    int n_bad = 0;

    stage_decode_redirect dut (
        .clk(clk), .rst(rst), .instrF(instrF), .pcF(pcF),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rdX(rdX), .is_loadX(is_loadX),
        .stallF(stallF), .pc_selD(pc_selD), .jump_result(jump_result),
        .branch_result(branch_result), .instrX(instrX), .pcX(pcX), .immX(immX),
        .validX(validX), .misalignX(misalignX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] t;
        t = v << (32 - bits);
        return $signed(t) >>> (32 - bits);
    endfunction

    function automatic logic [31:0] f_immI(input logic [31:0] i); return sx(i >> 20, 12); endfunction
    function automatic logic [31:0] f_immB(input logic [31:0] i);
        return sx(((i >> 31) << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1), 13);
    endfunction
    function automatic logic [31:0] f_immJ(input logic [31:0] i);
        return sx(((i >> 31) << 20) | (i & 32'h000F_F000) | (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1), 21);
    endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] i);
        case (i & 32'h7F)
            32'h03, 32'h13, 32'h67: return f_immI(i);
            32'h23: return sx(((i >> 25) << 5) | ((i >> 7) & 32'h1F), 12);
            32'h63: return f_immB(i);
            32'h37, 32'h17: return i & 32'hFFFF_F000;
            32'h6F: return f_immJ(i);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit f_hz(input logic [31:0] i, input bit v, input bit ld, input logic [4:0] rd);
        logic [6:0] op;
        bit r1, r2;
        op = i[6:0];
        r1 = (op == 7'h67 || op == 7'h63 || op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33);
        r2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
        return v && ld && rd != 0 && ((r1 && rd == i[19:15]) || (r2 && rd == i[24:20]));
    endfunction

    function automatic logic [1:0] f_sel(input logic [31:0] i, input bit v, input bit hz,
                                         input logic [31:0] a, input logic [31:0] b);
        bit tk;
        if (!v || hz) return 2'd0;
        if (i[6:0] == 7'h6F || i[6:0] == 7'h67) return 2'd1;
        if (i[6:0] != 7'h63) return 2'd0;
        case (i[14:12])
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 0;
        endcase
        return tk ? 2'd2 : 2'd0;
    endfunction

    function automatic logic [31:0] f_tgt(input logic [31:0] i, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [1:0] sel);
        if (sel == 2'd1) return (i[6:0] == 7'h67) ? ((a + f_immI(i)) & 32'hFFFF_FFFE) : (pc + f_immJ(i));
        if (sel == 2'd2) return pc + f_immB(i);
        return 32'h0;
    endfunction

    function automatic bit f_mis(input logic [31:0] i, input bit v, input bit hz, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [1:0]  s;
        logic [31:0] t;
        s = f_sel(i, v, hz, a, b);
        t = f_tgt(i, pc, a, s);
        return (s != 0) && t[1];
    endfunction

    logic [31:0] m_dI, m_dP, m_xI, m_xP, m_xImm;
    bit          m_dV, m_xV, m_xMis, live = 0;

    always @(posedge clk) begin
        if (rst) begin
            live   <= 1;
            m_dI   <= NOPI; m_dP <= RST_PC; m_dV <= 0;
            m_xI   <= NOPI; m_xP <= RST_PC; m_xImm <= 0; m_xV <= 0; m_xMis <= 0;
        end else begin
            m_xMis <= f_mis(m_dI, m_dV, f_hz(m_dI, m_dV, is_loadX, rdX), m_dP, rs1_data, rs2_data);
            if (f_hz(m_dI, m_dV, is_loadX, rdX)) begin
                m_xI <= NOPI; m_xV <= 0; m_xImm <= 0;
            end else begin
                m_xI   <= m_dV ? m_dI : NOPI;
                m_xImm <= m_dV ? f_imm(m_dI) : 32'h0;
                m_xP   <= m_dP;
                m_xV   <= m_dV;
                m_dI   <= instrF; m_dP <= pcF; m_dV <= (instrF != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            automatic bit         hz  = f_hz(m_dI, m_dV, is_loadX, rdX);
            automatic logic [1:0] sel = f_sel(m_dI, m_dV, hz, rs1_data, rs2_data);
            chk("m.stallF", {31'b0, stallF}, {31'b0, hz});
            chk("m.pc_selD", {30'b0, pc_selD}, {30'b0, sel});
            if (sel == 2'd1) chk("m.jump_result", jump_result, f_tgt(m_dI, m_dP, rs1_data, sel));
            if (sel == 2'd2) chk("m.branch_result", branch_result, f_tgt(m_dI, m_dP, rs1_data, sel));
            chk("m.instrX", instrX, m_xI);
            chk("m.pcX", pcX, m_xP);
            chk("m.immX", immX, m_xImm);
            chk("m.validX", {31'b0, validX}, {31'b0, m_xV});
            chk("m.misalignX", {31'b0, misalignX}, {31'b0, m_xMis});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick; @(posedge clk); #1; endtask
    task automatic setin(input logic [31:0] i, input logic [31:0] p); instrF = i; pcF = p; #3; endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".instrX"}, instrX, NOPI);
        chk({tag, ".pcX"}, pcX, RST_PC);
        chk({tag, ".validX"}, {31'b0, validX}, 32'd0);
        chk({tag, ".immX"}, immX, 32'd0);
        chk({tag, ".misalignX"}, {31'b0, misalignX}, 32'd0);
        chk({tag, ".stallF"}, {31'b0, stallF}, 32'd0);
        chk({tag, ".pc_selD"}, {30'b0, pc_selD}, 32'd0);
    endtask

    initial begin
        rst = 1; instrF = 0; pcF = 0; rs1_data = 0; rs2_data = 0; rdX = 0; is_loadX = 0;
        tick; tick;
        chk_reset("rst");
        rst = 0;

        // sequential ADDIs
        setin(ADDI, 32'h4000_0000); tick;
        setin(ADDI, 32'h4000_0004); chk("seq.sel", {30'b0, pc_selD}, 0); tick;
        chk("seq.validX", {31'b0, validX}, 1); chk("seq.pcX0", pcX, 32'h4000_0000);
        setin(ADDI, 32'h4000_0008); tick;
        chk("seq.pcX1", pcX, 32'h4000_0004);
        setin(0, 0); tick;
        chk("seq.pcX2", pcX, 32'h4000_0008);

        // JAL +16
        setin(JAL16, 32'h4000_0010); tick;
        setin(0, 0);
        chk("jal.sel", {30'b0, pc_selD}, 1); chk("jal.tgt", jump_result, 32'h4000_0020);
        tick;
        chk("jal.immX", immX, 32'd16);
        chk("jal.selclr", {30'b0, pc_selD}, 0);
        tick;
        chk("jal.bubble", {31'b0, validX}, 0);

        // BEQ taken / not taken
        rs1_data = 5; rs2_data = 5;
        setin(BEQ, 32'h4000_0040); tick;
        setin(0, 0);
        chk("beq.sel", {30'b0, pc_selD}, 2); chk("beq.tgt", branch_result, 32'h4000_0038);
        tick;
        rs2_data = 6;
        setin(BEQ, 32'h4000_0040); tick;
        setin(ADDI, 32'h4000_0044); chk("beqnt.sel", {30'b0, pc_selD}, 0); tick;
        setin(0, 0); tick;
        chk("beqnt.pcX", pcX, 32'h4000_0044); chk("beqnt.validX", {31'b0, validX}, 1);

        // signed vs unsigned compare
        rs1_data = 32'hFFFF_FFFF; rs2_data = 1;
        setin(BLT, 32'h4000_0040); tick;
        setin(BLTU, 32'h4000_0044); chk("blt.sel", {30'b0, pc_selD}, 2); tick;
        setin(0, 0); chk("bltu.sel", {30'b0, pc_selD}, 0); tick;

        // load-use stall on add x6,x5,x1
        rs1_data = 0; rs2_data = 0;
        setin(ADDI, 32'h4000_004C); tick;
        setin(ADD, 32'h4000_0050); tick;
        rdX = 5; is_loadX = 1;
        setin(ADDI, 32'h4000_0054);
        chk("lu.stall", {31'b0, stallF}, 1); chk("lu.sel", {30'b0, pc_selD}, 0);
        tick;
        chk("lu.nop", instrX, NOPI); chk("lu.validX", {31'b0, validX}, 0); chk("lu.pcXheld", pcX, 32'h4000_004C);
        rdX = 0; is_loadX = 0; #3;
        chk("lu.release", {31'b0, stallF}, 0);
        tick;
        chk("lu.instrX", instrX, ADD); chk("lu.pcX", pcX, 32'h4000_0050);
        setin(ADD, 32'h4000_0058); tick;
        rdX = 0; is_loadX = 1; setin(0, 0);
        chk("lu.x0", {31'b0, stallF}, 0);
        tick; is_loadX = 0;

        // load-use on taken BEQ
        rs1_data = 5; rs2_data = 5;
        setin(BEQ, 32'h4000_0040); tick;
        rdX = 1; is_loadX = 1; setin(0, 0);
        chk("lub.stall", {31'b0, stallF}, 1); chk("lub.sel0", {30'b0, pc_selD}, 0);
        tick;
        rdX = 0; is_loadX = 0; #3;
        chk("lub.sel2", {30'b0, pc_selD}, 2); chk("lub.tgt", branch_result, 32'h4000_0038);
        tick;

        // reset during a stall
        setin(BEQ, 32'h4000_0040); tick;
        rdX = 2; is_loadX = 1; setin(ADDI, 32'h4000_0044);
        chk("rs.stall", {31'b0, stallF}, 1);
        rst = 1; tick;
        chk_reset("rs");
        rst = 0; rdX = 0; is_loadX = 0;

        // misaligned JALR target
        rs1_data = 32'h4000_0102;
        setin(JALR, 32'h4000_0060); tick;
        setin(0, 0);
        chk("mis.sel", {30'b0, pc_selD}, 1); chk("mis.tgt", jump_result, 32'h4000_0102);
        tick;
        chk("mis.set", {31'b0, misalignX}, 1);
        tick;
        chk("mis.pulse", {31'b0, misalignX}, 0);

        // randomized traffic, model-checked every cycle
        for (int c = 0; c < 1500; c++) begin
            automatic logic [31:0] r  = $urandom();
            automatic logic [31:0] ins = r;
            automatic int          k  = $urandom_range(0, 9);
            ins[24:20] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[11:7]  = 5'($urandom_range(0, 3));
            case (k)
                0: ins[6:0] = 7'h13; 1: ins[6:0] = 7'h33; 2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23; 4, 5: ins[6:0] = 7'h63; 6: ins[6:0] = 7'h6F;
                7: ins[6:0] = 7'h67; 8: ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
                default: ins = 0;
            endcase
            rs1_data = $urandom();
            rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom();
            if ($urandom_range(0, 3) == 0) rs1_data = {31'b0, rs1_data[0]} - 1;
            rdX      = 5'($urandom_range(0, 3));
            is_loadX = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            instrF   = ins;
            pcF      = (ins == 0) ? 32'h0 : (32'h4000_0000 | ($urandom() & 32'h0000_FFFE));
            tick;
        end
        rst = 0;
        tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stage_decode_redirect.md
Name: stage_decode_redirect

Overview:
Decode-side partner of the fetch stage. It registers the fetched instruction and PC, and resolves JAL/JALR/conditional branches in decode. It drives the redirect interface back to fetch (pc_selD, jump_result, branch_result) and detects load-use hazards, which drive stallF. It also forwards a registered decoded instruction to the execute stage.

Parameters:
XLEN, 32, datapath width; equals `XLEN from defines.v.
RESET_PC, 32'h4000_0000, reset value of pcD/pcX (BIOS base).
NOP_INSTR, 32'h0000_0013, instruction emitted as a bubble (addi x0,x0,0).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
instrF  in  XLEN  instruction from fetch; 0 denotes a squashed slot.
pcF  in  XLEN  PC of instrF; 0 when fetch squashes.
rs1_data  in  XLEN  forwarded rs1 value for the instruction in D.
rs2_data  in  XLEN  forwarded rs2 value for the instruction in D.
rdX  in  5  destination register of the instruction in execute.
is_loadX  in  1  instruction in execute is a load.
stallF  out  1  hold fetch PC register.
pc_selD  out  2  00 sequential, 01 jump, 10 branch; 11 never driven.
jump_result  out  XLEN  JAL/JALR target.
branch_result  out  XLEN  taken-branch target.
instrX  out  XLEN  registered instruction to execute.
pcX  out  XLEN  registered PC to execute.
immX  out  XLEN  registered sign-extended immediate.
validX  out  1  instrX is a real instruction.
misalignX  out  1  redirect target had bit[1] set (one-cycle pulse, registered).

Behaviour:
- D register (instrD, pcD, validD) loads instrF/pcF on each posedge unless stalled. validD = (instrF != 0).
- Combinational decode of D uses the imm_gen immediates.
  - JAL target = pcD + immJ.
  - JALR target = (rs1_data + immI) & ~1.
  - Branch target = pcD + immB.
- Branch compare by funct3: BEQ, BNE, BLT, BGE (signed); BLTU, BGEU (unsigned). Any other funct3 is not-taken.
- Hazard: hz = validD & is_loadX & (rdX != 0) & (rdX == rs1D or rdX == rs2D), where the rs field is used by the opcode. stallF = hz.
- Redirect selection:
  - pc_selD = 01 for JAL/JALR, 10 for a taken branch, else 00.
  - Forced to 00 while validD = 0 or hz = 1 (stall has priority).
- Redirect pulse: the redirect is asserted for exactly one cycle.
  - Fetch zeroes instrF in that cycle, so D captures a bubble at the edge.
  - The redirect therefore self-clears; the net penalty is one bubble.
- jump_result and branch_result always show the computed targets; they are meaningful only when the matching pc_selD value is set.
- X register, on each posedge:
  - If hz: instrX = NOP_INSTR, validX = 0, immX = 0. pcX is held; D is held.
  - Otherwise: X loads instrD, pcD, imm, validD.
  - Invalid slots carry NOP_INSTR.
- misalignX is registered with X: it is set when a redirect fires with target[1] = 1. The redirect still occurs (no trap).
- Reset:
  - instrD = instrX = NOP_INSTR; pcD = pcX = RESET_PC; validD = validX = 0; immX = 0; misalignX = 0.
  - Combinational outputs follow (pc_selD = 00, stallF = 0).
- Reset mid-stall or mid-redirect: all state returns to reset values on the reset edge. No pending redirect survives reset.
- x0 destination never causes a stall. Back-to-back load-use on both rs1 and rs2 is a single stall cycle.

Decomposition:
- Add to defines.v:
  - opcode constants: OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, etc.
  - branch funct3 codes.
  - PC_SEL_SEQ = 2'b00, PC_SEL_JUMP = 2'b01, PC_SEL_BRANCH = 2'b10.
  - NOP constant.
- One sub-module: imm_gen (combinational). Produces I/S/B/U/J immediates from a 32-bit instruction, plus an immediate-select output.

Test Plan:
- Reset then 3 sequential ADDIs at pcF 0x4000_0000/4/8 -> pc_selD = 00 throughout; validX rises 2 cycles after the first instr; pcX sequence 0x4000_0000, 0x4000_0004, 0x4000_0008.
- JAL imm = +16 at pcD 0x4000_0010 -> pc_selD = 01 for one cycle; jump_result = 0x4000_0020; next X slot is validX = 0.
- BEQ with rs1 = rs2 = 5, imm = -8, at pcD 0x4000_0040 -> pc_selD = 10, branch_result = 0x4000_0038. Same stimulus with rs2 = 6 -> pc_selD = 00, no bubble.
- BLT with rs1 = 0xFFFF_FFFF, rs2 = 1 -> taken. BLTU with the same operands -> not taken.
- LW x5 in X (is_loadX = 1, rdX = 5) with `add x6,x5,x1` in D -> stallF = 1 for one cycle; X gets NOP; D and pcD held; the following cycle proceeds. Same test with rdX = 0 -> no stall.
- Load-use on a BEQ with a taken outcome -> pc_selD = 00 during the stall cycle, then 10 in the next cycle. Assert rst during the stall -> all outputs return to reset values next cycle.
